// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sample path: sample format and the
// measurement FSM state encoding.
package awg_pkg;

  localparam int unsigned AWG_DW  = 14;
  localparam int unsigned AWG_MID = 8192;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meas_state_e;

endpackage

// File: rtl/wave_meas_schmitt_det.sv
// Hysteresis comparator around midscale; rise_pulse flags the LO->HI
// transition on the qualifying sample itself (no added latency).
module schmitt_det
  import awg_pkg::*;
#(
  parameter int unsigned DW   = AWG_DW,
  parameter int unsigned MID  = AWG_MID,
  parameter int unsigned HYST = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  output logic          level,
  output logic          rise_pulse
);

  // Thresholds kept one bit wider than the sample so MID+HYST cannot wrap.
  localparam logic [DW:0] HI_THR = (DW+1)'(MID + HYST);
  localparam logic [DW:0] LO_THR = (DW+1)'(MID - HYST);

  logic        level_q, level_d;
  logic [DW:0] s_ext;
  logic        above, below;

  assign s_ext = {1'b0, sample};
  assign above = (s_ext >= HI_THR);
  assign below = (s_ext <= LO_THR);

  always_comb begin
    level_d = level_q;
    if (sample_valid) begin
      if (!level_q && above)
        level_d = 1'b1;
      else if (level_q && below)
        level_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      level_q <= 1'b0;
    else
      level_q <= level_d;
  end

  assign level      = level_q;
  assign rise_pulse = sample_valid & ~level_q & above;

endmodule

// File: rtl/wave_meas.sv
// Period / peak measurement over NPER rising crossings of the sample stream,
// with a sample-count timeout and a one-cycle result pulse.
module wave_meas
  import awg_pkg::*;
#(
  parameter int unsigned DW      = AWG_DW,
  parameter int unsigned MID     = AWG_MID,
  parameter int unsigned HYST    = 64,
  parameter int unsigned NPER    = 4,
  parameter int unsigned PW      = 20,
  parameter int unsigned TIMEOUT = (1 << 20) - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  output logic          result_valid,
  output logic [PW-1:0] period,
  output logic [PW+5:0] period_sum,
  output logic [DW-1:0] peak_max,
  output logic [DW-1:0] peak_min,
  output logic [DW-1:0] pp_amp,
  output logic          timeout,
  output logic          locked
);

  localparam int unsigned SH  = $clog2(NPER);
  localparam int unsigned NCW = SH + 1;

  meas_state_e   state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NCW-1:0] ncross_q, ncross_d, ncross_inc;
  logic [DW-1:0] max_q, max_d, min_q, min_d, smax, smin;

  logic          rv_q, rv_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW+5:0] psum_q, psum_d;
  logic [DW-1:0] pmax_q, pmax_d, pmin_q, pmin_d, pp_q, pp_d;
  logic          to_q, to_d;

  logic level, rise_pulse, rise_evt;

  schmitt_det #(
    .DW   (DW),
    .MID  (MID),
    .HYST (HYST)
  ) u_schmitt (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .rise_pulse   (rise_pulse)
  );

  assign rise_evt   = rise_pulse & ~level;
  assign cnt_inc    = cnt_q + 1'b1;
  assign ncross_inc = ncross_q + 1'b1;
  assign smax       = (sample > max_q) ? sample : max_q;
  assign smin       = (sample < min_q) ? sample : min_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ncross_d = ncross_q;
    max_d    = max_q;
    min_d    = min_q;
    rv_d     = 1'b0;
    period_d = period_q;
    psum_d   = psum_q;
    pmax_d   = pmax_q;
    pmin_d   = pmin_q;
    pp_d     = pp_q;
    to_d     = to_q;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;

        ST_ARM: begin
          if (rise_evt) begin
            state_d  = ST_MEAS;
            cnt_d    = '0;
            ncross_d = '0;
            max_d    = sample;
            min_d    = sample;
          end
        end

        ST_MEAS: begin
          if (sample_valid) begin
            cnt_d = cnt_inc;
            max_d = smax;
            min_d = smin;
            if (rise_evt)
              ncross_d = ncross_inc;
            // Completion is tested first so it wins over a coincident timeout;
            // the completing sample also seeds the next window.
            if (rise_evt && (ncross_inc == NCW'(NPER))) begin
              rv_d     = 1'b1;
              to_d     = 1'b0;
              psum_d   = (PW+6)'(cnt_inc);
              period_d = cnt_inc >> SH;
              pmax_d   = smax;
              pmin_d   = smin;
              pp_d     = smax - smin;
              cnt_d    = '0;
              ncross_d = '0;
              max_d    = sample;
              min_d    = sample;
            end else if (cnt_inc == PW'(TIMEOUT)) begin
              rv_d     = 1'b1;
              to_d     = 1'b1;
              psum_d   = '0;
              period_d = '0;
              pmax_d   = smax;
              pmin_d   = smin;
              pp_d     = smax - smin;
              state_d  = ST_ARM;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ncross_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
      rv_q     <= 1'b0;
      period_q <= '0;
      psum_q   <= '0;
      pmax_q   <= '0;
      pmin_q   <= '0;
      pp_q     <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ncross_q <= ncross_d;
      max_q    <= max_d;
      min_q    <= min_d;
      rv_q     <= rv_d;
      period_q <= period_d;
      psum_q   <= psum_d;
      pmax_q   <= pmax_d;
      pmin_q   <= pmin_d;
      pp_q     <= pp_d;
      to_q     <= to_d;
    end
  end

  assign result_valid = rv_q;
  assign period       = period_q;
  assign period_sum   = psum_q;
  assign peak_max     = pmax_q;
  assign peak_min     = pmin_q;
  assign pp_amp       = pp_q;
  assign timeout      = to_q;
  assign locked       = (state_q == ST_MEAS);

endmodule

// File: tb/tb_wave_meas.sv
// Directed bench for wave_meas: square, uneven periods, sine, gapped valid,
// enable drop, mid-window reset and timeout on a noise floor.
module tb_wave_meas;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [13:0] sample = 14'd8192;
  logic        result_valid;
  logic [19:0] period;
  logic [25:0] period_sum;
  logic [13:0] peak_max, peak_min, pp_amp;
  logic        timeout, locked;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cur_k = 0;
  int pk[$];
  int pc[$];
  int pv[$];
  int exp_q[$];

  wave_meas #(
    .DW      (14),
    .MID     (8192),
    .HYST    (64),
    .NPER    (4),
    .PW      (20),
    .TIMEOUT (1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_valid (sample_valid),
    .sample       (sample),
    .result_valid (result_valid),
    .period       (period),
    .period_sum   (period_sum),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .pp_amp       (pp_amp),
    .timeout      (timeout),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic v, input logic [13:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
    cyc++;
    if (result_valid) begin
      pk.push_back(cur_k);
      pc.push_back(cyc);
      pv.push_back(int'(v));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int per, input int sum, input int mx,
                         input int mn, input int pp, input int to);
    chk({tag, ":period"},     32'(period),     per);
    chk({tag, ":period_sum"}, 32'(period_sum), sum);
    chk({tag, ":peak_max"},   32'(peak_max),   mx);
    chk({tag, ":peak_min"},   32'(peak_min),   mn);
    chk({tag, ":pp_amp"},     32'(pp_amp),     pp);
    chk({tag, ":timeout"},    32'(timeout),    to);
  endtask

  task automatic chk_pulses(input string tag);
    chk({tag, ":npulse"}, pk.size(), exp_q.size());
    foreach (exp_q[i])
      chk({tag, ":pulse_k"}, (i < pk.size()) ? pk[i] : -1, exp_q[i]);
    pk.delete();
    pc.delete();
    pv.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick(1'b0, 14'd8192);
    tick(1'b0, 14'd8192);
    rst = 1'b0;
    pk.delete();
    pc.delete();
    pv.delete();
  endtask

  function automatic logic [13:0] sq(input int k);
    return ((k % 100) < 50) ? 14'd4096 : 14'd12288;
  endfunction

  initial begin
    // Reset state
    do_reset();
    chk("reset:result_valid", 32'(result_valid), 0);
    chk("reset:locked", 32'(locked), 0);
    chk_out("reset", 0, 0, 0, 0, 0, 0);

    // Continuous square wave, then en dropped 250 samples into a window
    en = 1'b1;
    tick(1'b0, 14'd8192);
    for (int k = 0; k <= 1100; k++) begin cur_k = k; tick(1'b1, sq(k)); end
    chk("square:locked", 32'(locked), 1);
    chk_out("square", 100, 400, 12288, 4096, 8192, 0);
    en = 1'b0;
    for (int k = 1101; k < 1120; k++) begin cur_k = k; tick(1'b1, sq(k)); end
    chk("endrop:locked", 32'(locked), 0);
    chk_out("endrop_hold", 100, 400, 12288, 4096, 8192, 0);
    en = 1'b1;
    for (int k = 1120; k <= 1600; k++) begin cur_k = k; tick(1'b1, sq(k)); end
    exp_q = '{450, 850, 1550};
    chk_pulses("square_en");

    // Periods 101,100,100,100: sum 401, average truncates to 100
    do_reset();
    en = 1'b1;
    tick(1'b0, 14'd8192);
    for (int k = 0; k < 521; k++) begin
      cur_k = k;
      if (k < 50)        tick(1'b1, 14'd4096);
      else if (k < 100)  tick(1'b1, 14'd12288);
      else if (k < 151)  tick(1'b1, 14'd4096);
      else if (k < 201)  tick(1'b1, 14'd12288);
      else               tick(1'b1, sq(k - 1));
    end
    chk_out("uneven", 100, 401, 12288, 4096, 8192, 0);
    exp_q = '{451};
    chk_pulses("uneven");

    // Sine +-2000 about midscale, period 64
    do_reset();
    en = 1'b1;
    tick(1'b0, 14'd8192);
    for (int k = 0; k < 320; k++) begin
      real x;
      x = 8192.0 + 2000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0) + 0.5;
      cur_k = k;
      tick(1'b1, 14'($rtoi(x)));
    end
    chk_out("sine", 64, 256, 10192, 6192, 4000, 0);
    exp_q = '{257};
    chk_pulses("sine");

    // Square with valid every 3rd clk, then reset 150 samples into a window
    do_reset();
    en = 1'b1;
    tick(1'b0, 14'd8192);
    for (int k = 0; k <= 1000; k++) begin
      cur_k = k;
      tick(1'b0, sq(k));
      tick(1'b0, sq(k));
      tick(1'b1, sq(k));
    end
    chk_out("gap", 100, 400, 12288, 4096, 8192, 0);
    if (pc.size() >= 2) begin
      chk("gap:pulse_spacing", pc[1] - pc[0], 1200);
      chk("gap:pulse0_on_valid", pv[0], 1);
      chk("gap:pulse1_on_valid", pv[1], 1);
    end else begin
      chk("gap:npulse_early", pc.size(), 2);
    end
    rst = 1'b1;
    tick(1'b0, 14'd4096);
    rst = 1'b0;
    chk("midrst:result_valid", 32'(result_valid), 0);
    chk("midrst:locked", 32'(locked), 0);
    chk_out("midrst", 0, 0, 0, 0, 0, 0);
    for (int k = 1001; k <= 1500; k++) begin cur_k = k; tick(1'b1, sq(k)); end
    chk_out("after_rst", 100, 400, 12288, 4096, 8192, 0);
    exp_q = '{450, 850, 1450};
    chk_pulses("gap_rst");

    // Lock, then noise +-32 about midscale until timeout
    do_reset();
    en = 1'b1;
    tick(1'b0, 14'd8192);
    for (int k = 0; k < 1200; k++) begin
      cur_k = k;
      if (k < 50)       tick(1'b1, 14'd4096);
      else if (k < 60)  tick(1'b1, 14'd12288);
      else              tick(1'b1, 14'(8192 + ((k % 5) - 2) * 16));
    end
    chk_out("timeout", 0, 0, 12288, 8160, 4128, 1);
    chk("timeout:locked", 32'(locked), 0);
    exp_q = '{1050};
    chk_pulses("timeout");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
